// File: rtl/hazard_scheduler_pkg.sv
// Shared pipeline types for the hazard scheduler: control encodings, forward
// selects, scoreboard entry layout and the producer ready-stage lookup.
package hazard_scheduler_pkg;

  localparam int SB_ID_WIDTH  = 5;
  localparam int SB_CNT_WIDTH = 32;

  typedef enum logic [1:0] {
    DECODE     = 2'd0,
    EXECUATION = 2'd1,
    MEMORY     = 2'd2,
    NONE       = 2'd3
  } register_data_required_stage_t;

  typedef enum logic [1:0] {
    ALU_RESULT    = 2'd0,
    DM_READ       = 2'd1,
    PC_ADD_8      = 2'd2,
    IMME_LSHIFTED = 2'd3
  } reg_write_from_t;

  typedef enum logic [1:0] {
    FWD_NONE = 2'd0,
    FWD_MEM  = 2'd1,
    FWD_WB   = 2'd2
  } forward_src_t;

  typedef struct packed {
    logic                   valid;
    logic [SB_ID_WIDTH-1:0] write_id;
    logic [1:0]             ready_stage;
  } scoreboard_entry_t;

  // Stage index (ID=0 .. WB=3) at which the producer's result first exists.
  function automatic logic [1:0] ready_stage_of(input reg_write_from_t wf);
    case (wf)
      ALU_RESULT: return 2'd1;
      DM_READ:    return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/hazard_operand_check.sv
// One source operand against the EX/MEM/WB scoreboard: youngest matching
// producer decides between interlock and a forward path.
module hazard_operand_check
  import hazard_scheduler_pkg::*;
(
  input  logic                          i_id_valid,
  input  logic [SB_ID_WIDTH-1:0]        i_read_id,
  input  register_data_required_stage_t i_need,
  input  scoreboard_entry_t             i_ex,
  input  scoreboard_entry_t             i_mem,
  input  scoreboard_entry_t             i_wb,
  output logic                          o_hazard,
  output forward_src_t                  o_fwd_sel
);

  logic       w_check;
  logic       w_hit;
  logic [2:0] w_sum;
  logic [1:0] w_ready;

  // w_sum is the stage the producer occupies when the consumer needs the value.
  always_comb begin
    w_check = i_id_valid && (i_read_id != '0) && (i_need != NONE);
    w_hit   = 1'b0;
    w_sum   = 3'd0;
    w_ready = 2'd0;
    if (i_ex.valid && (i_ex.write_id == i_read_id)) begin
      w_hit   = 1'b1;
      w_sum   = 3'd1 + {1'b0, i_need};
      w_ready = i_ex.ready_stage;
    end else if (i_mem.valid && (i_mem.write_id == i_read_id)) begin
      w_hit   = 1'b1;
      w_sum   = 3'd2 + {1'b0, i_need};
      w_ready = i_mem.ready_stage;
    end else if (i_wb.valid && (i_wb.write_id == i_read_id)) begin
      w_hit   = 1'b1;
      w_sum   = 3'd3 + {1'b0, i_need};
      w_ready = i_wb.ready_stage;
    end else begin
      w_hit   = 1'b0;
    end

    o_hazard  = 1'b0;
    o_fwd_sel = FWD_NONE;
    if (w_check && w_hit) begin
      if (w_sum <= {1'b0, w_ready}) begin
        o_hazard = 1'b1;
      end else if (w_sum == 3'd2) begin
        o_fwd_sel = FWD_MEM;
      end else if (w_sum == 3'd3) begin
        o_fwd_sel = FWD_WB;
      end else begin
        o_fwd_sel = FWD_NONE;
      end
    end else begin
      o_hazard = 1'b0;
    end
  end

endmodule

// File: rtl/hazard_scheduler.sv
// Interlock and forwarding scheduler for the 5-stage core: tracks in-flight
// GPR writes in EX/MEM/WB and stalls or forwards the ID instruction.
module hazard_scheduler
  import hazard_scheduler_pkg::*;
#(
  parameter int REG_ID_WIDTH = SB_ID_WIDTH,
  parameter int CNT_WIDTH    = SB_CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          id_valid,
  input  logic [REG_ID_WIDTH-1:0]       id_read_id1,
  input  logic [REG_ID_WIDTH-1:0]       id_read_id2,
  input  register_data_required_stage_t id_required,
  input  logic                          id_write_en,
  input  logic [REG_ID_WIDTH-1:0]       id_write_id,
  input  reg_write_from_t               id_write_from,
  input  logic                          mem_busy,
  output logic                          stall_front,
  output logic                          bubble_ex,
  output logic                          freeze_all,
  output forward_src_t                  fwd_sel1,
  output forward_src_t                  fwd_sel2,
  output logic [CNT_WIDTH-1:0]          stall_count
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  scoreboard_entry_t      r_sb_ex;
  scoreboard_entry_t      r_sb_mem;
  scoreboard_entry_t      r_sb_wb;
  scoreboard_entry_t      w_id_entry;
  logic                   w_haz1;
  logic                   w_haz2;
  logic                   w_hazard;
  logic [CNT_WIDTH-1:0]   r_stall_count;

  hazard_operand_check u_op1 (
    .i_id_valid (id_valid),
    .i_read_id  (id_read_id1),
    .i_need     (id_required),
    .i_ex       (r_sb_ex),
    .i_mem      (r_sb_mem),
    .i_wb       (r_sb_wb),
    .o_hazard   (w_haz1),
    .o_fwd_sel  (fwd_sel1)
  );

  hazard_operand_check u_op2 (
    .i_id_valid (id_valid),
    .i_read_id  (id_read_id2),
    .i_need     (id_required),
    .i_ex       (r_sb_ex),
    .i_mem      (r_sb_mem),
    .i_wb       (r_sb_wb),
    .o_hazard   (w_haz2),
    .o_fwd_sel  (fwd_sel2)
  );

  // Writes to $0 never create a producer entry.
  always_comb begin
    w_id_entry.valid       = id_valid && id_write_en && (id_write_id != '0);
    w_id_entry.write_id    = id_write_id;
    w_id_entry.ready_stage = ready_stage_of(id_write_from);
  end

  assign w_hazard    = w_haz1 | w_haz2;
  assign stall_front = w_hazard & ~mem_busy;
  assign bubble_ex   = w_hazard & ~mem_busy;
  assign freeze_all  = mem_busy;
  assign stall_count = r_stall_count;

  // Scoreboard advance and stall counter; memory freeze outranks interlock.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_sb_ex       <= '0;
      r_sb_mem      <= '0;
      r_sb_wb       <= '0;
      r_stall_count <= '0;
    end else if (mem_busy) begin
      r_sb_ex       <= r_sb_ex;
      r_sb_mem      <= r_sb_mem;
      r_sb_wb       <= r_sb_wb;
      r_stall_count <= r_stall_count;
    end else if (w_hazard) begin
      r_sb_wb       <= r_sb_mem;
      r_sb_mem      <= r_sb_ex;
      r_sb_ex       <= '0;
      r_stall_count <= (&r_stall_count) ? r_stall_count : r_stall_count + CNT_ONE;
    end else begin
      r_sb_wb       <= r_sb_mem;
      r_sb_mem      <= r_sb_ex;
      r_sb_ex       <= w_id_entry;
      r_stall_count <= r_stall_count;
    end
  end

endmodule

// File: tb/tb_hazard_scheduler.sv
// Self-checking bench: directed MIPS hazard scenarios plus random traffic,
// compared every cycle against an instruction-level pipeline model.
module tb_hazard_scheduler;
  import hazard_scheduler_pkg::*;

  logic                          clock = 1'b0;
  logic                          reset = 1'b1;
  logic                          id_valid = 1'b0;
  logic [4:0]                    id_read_id1 = 5'd0;
  logic [4:0]                    id_read_id2 = 5'd0;
  register_data_required_stage_t id_required = NONE;
  logic                          id_write_en = 1'b0;
  logic [4:0]                    id_write_id = 5'd0;
  reg_write_from_t               id_write_from = ALU_RESULT;
  logic                          mem_busy = 1'b0;
  logic                          stall_front;
  logic                          bubble_ex;
  logic                          freeze_all;
  forward_src_t                  fwd_sel1;
  forward_src_t                  fwd_sel2;
  logic [31:0]                   stall_count;

  hazard_scheduler dut (
    .clock(clock), .reset(reset), .id_valid(id_valid),
    .id_read_id1(id_read_id1), .id_read_id2(id_read_id2),
    .id_required(id_required), .id_write_en(id_write_en),
    .id_write_id(id_write_id), .id_write_from(id_write_from),
    .mem_busy(mem_busy), .stall_front(stall_front), .bubble_ex(bubble_ex),
    .freeze_all(freeze_all), .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;

  // Driven instruction, kept as plain integers for the model.
  int b_rst = 1, b_v = 0, b_r1 = 0, b_r2 = 0, b_req = 3;
  int b_we = 0, b_wid = 0, b_wf = 0, b_busy = 0;

  // Model: in-flight writers by stage distance from ID (1=EX, 2=MEM, 3=WB).
  int     m_valid[4];
  int     m_id[4];
  int     m_ready[4];
  longint m_cnt;
  int     ready_tab[4] = '{1, 2, 0, 0};

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, got, exp, $time);
    end
  endtask

  // Operand outcome: consumer needs value at stage c, youngest producer decides.
  task automatic op_eval(input int rid, output int haz, output int fwd);
    haz = 0;
    fwd = 0;
    if (b_v == 0 || rid == 0 || b_req == 3) return;
    for (int p = 1; p <= 3; p++) begin
      if (m_valid[p] != 0 && m_id[p] == rid) begin
        if (p + b_req <= m_ready[p]) haz = 1;
        else if (p + b_req == 2) fwd = 1;
        else if (p + b_req == 3) fwd = 2;
        return;
      end
    end
  endtask

  task automatic model_check();
    int h1, f1, h2, f2, hz;
    op_eval(b_r1, h1, f1);
    op_eval(b_r2, h2, f2);
    hz = h1 | h2;
    chk("stall_front", 64'(stall_front), 64'(hz != 0 && b_busy == 0));
    chk("bubble_ex",   64'(bubble_ex),   64'(hz != 0 && b_busy == 0));
    chk("freeze_all",  64'(freeze_all),  64'(b_busy));
    chk("fwd_sel1",    64'(fwd_sel1),    64'(f1));
    chk("fwd_sel2",    64'(fwd_sel2),    64'(f2));
    chk("stall_count", 64'(stall_count), 64'(m_cnt));
  endtask

  task automatic model_update();
    int h1, f1, h2, f2;
    op_eval(b_r1, h1, f1);
    op_eval(b_r2, h2, f2);
    if (b_rst != 0) begin
      for (int i = 1; i <= 3; i++) m_valid[i] = 0;
      m_cnt = 0;
    end else if (b_busy == 0) begin
      for (int i = 3; i >= 2; i--) begin
        m_valid[i] = m_valid[i-1];
        m_id[i]    = m_id[i-1];
        m_ready[i] = m_ready[i-1];
      end
      if ((h1 | h2) != 0) begin
        m_valid[1] = 0;
        if (m_cnt < 64'hFFFF_FFFF) m_cnt = m_cnt + 1;
      end else begin
        m_valid[1] = (b_v != 0 && b_we != 0 && b_wid != 0) ? 1 : 0;
        m_id[1]    = b_wid;
        m_ready[1] = ready_tab[b_wf];
      end
    end
  endtask

  // One cycle: retire previous inputs at posedge, drive new ones, check mid-low.
  task automatic apply(input int rst, input int v, input int r1, input int r2,
                       input int req, input int we, input int wid, input int wf,
                       input int busy);
    @(posedge clock);
    model_update();
    @(negedge clock);
    b_rst = rst; b_v = v; b_r1 = r1; b_r2 = r2; b_req = req;
    b_we = we; b_wid = wid; b_wf = wf; b_busy = busy;
    reset         = 1'(rst);
    id_valid      = 1'(v);
    id_read_id1   = 5'(r1);
    id_read_id2   = 5'(r2);
    id_required   = register_data_required_stage_t'(2'(req));
    id_write_en   = 1'(we);
    id_write_id   = 5'(wid);
    id_write_from = reg_write_from_t'(2'(wf));
    mem_busy      = 1'(busy);
    #1;
    model_check();
  endtask

  task automatic do_reset();
    apply(1, 0, 0, 0, 3, 0, 0, 0, 0);
    apply(0, 0, 0, 0, 3, 0, 0, 0, 0);
  endtask

  initial begin
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 0; m_id[i] = 0; m_ready[i] = 0;
    end
    m_cnt = 0;

    // Empty scoreboard after reset.
    do_reset();
    chk("lit_reset_cnt", 64'(stall_count), 64'd0);
    chk("lit_reset_stall", 64'(stall_front), 64'd0);

    // 1: add $3,$1,$2 ; add $4,$3,$3
    apply(0, 1, 1, 2, 1, 1, 3, 0, 0);
    apply(0, 1, 3, 3, 1, 1, 4, 0, 0);
    chk("lit_t1_fwd1", 64'(fwd_sel1), 64'(FWD_MEM));
    chk("lit_t1_fwd2", 64'(fwd_sel2), 64'(FWD_MEM));
    chk("lit_t1_stall", 64'(stall_front), 64'd0);

    // 2: lw $5,0($1) ; add $6,$5,$0
    do_reset();
    apply(0, 1, 1, 0, 1, 1, 5, 1, 0);
    apply(0, 1, 5, 0, 1, 1, 6, 0, 0);
    chk("lit_t2_stall", 64'(stall_front), 64'd1);
    chk("lit_t2_bubble", 64'(bubble_ex), 64'd1);
    apply(0, 1, 5, 0, 1, 1, 6, 0, 0);
    chk("lit_t2_fwd1", 64'(fwd_sel1), 64'(FWD_WB));
    chk("lit_t2_cnt", 64'(stall_count), 64'd1);

    // 3: add $7 ; beq $7,$0
    do_reset();
    apply(0, 1, 1, 2, 1, 1, 7, 0, 0);
    apply(0, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("lit_t3_stall", 64'(stall_front), 64'd1);
    apply(0, 1, 7, 0, 0, 0, 0, 0, 0);
    chk("lit_t3_nostall", 64'(stall_front), 64'd0);
    chk("lit_t3_fwd1", 64'(fwd_sel1), 64'(FWD_MEM));

    // 4: lw $8 ; beq $8 -> two stalls
    do_reset();
    apply(0, 1, 1, 0, 1, 1, 8, 1, 0);
    apply(0, 1, 8, 0, 0, 0, 0, 0, 0);
    chk("lit_t4_stall_a", 64'(stall_front), 64'd1);
    apply(0, 1, 8, 0, 0, 0, 0, 0, 0);
    chk("lit_t4_stall_b", 64'(stall_front), 64'd1);
    apply(0, 1, 8, 0, 0, 0, 0, 0, 0);
    chk("lit_t4_go", 64'(stall_front), 64'd0);
    chk("lit_t4_fwd1", 64'(fwd_sel1), 64'(FWD_WB));
    chk("lit_t4_cnt", 64'(stall_count), 64'd2);

    // 5: add $9 ; sw $9,0($2)
    do_reset();
    apply(0, 1, 1, 2, 1, 1, 9, 0, 0);
    apply(0, 1, 2, 9, 2, 0, 0, 0, 0);
    chk("lit_t5_stall", 64'(stall_front), 64'd0);
    chk("lit_t5_fwd2", 64'(fwd_sel2), 64'(FWD_WB));

    // 6a: add $0 ; add $1,$0,$0
    do_reset();
    apply(0, 1, 1, 2, 1, 1, 0, 0, 0);
    apply(0, 1, 0, 0, 1, 1, 1, 0, 0);
    chk("lit_t6_stall", 64'(stall_front), 64'd0);
    chk("lit_t6_fwd1", 64'(fwd_sel1), 64'(FWD_NONE));

    // 6b: load-use under 3 cycles of mem_busy
    do_reset();
    apply(0, 1, 1, 0, 1, 1, 5, 1, 0);
    for (int k = 0; k < 3; k++) begin
      apply(0, 1, 5, 0, 1, 1, 6, 0, 1);
      chk("lit_t6b_frz_stall", 64'(stall_front), 64'd0);
      chk("lit_t6b_frz_freeze", 64'(freeze_all), 64'd1);
      chk("lit_t6b_frz_cnt", 64'(stall_count), 64'd0);
    end
    apply(0, 1, 5, 0, 1, 1, 6, 0, 0);
    chk("lit_t6b_resume_stall", 64'(stall_front), 64'd1);
    apply(0, 1, 5, 0, 1, 1, 6, 0, 0);
    chk("lit_t6b_after", 64'(stall_front), 64'd0);
    chk("lit_t6b_cnt", 64'(stall_count), 64'd1);

    // Reset during a stall, and self-dependency
    do_reset();
    apply(0, 1, 1, 0, 1, 1, 5, 1, 0);
    apply(1, 1, 5, 0, 1, 1, 6, 0, 0);
    chk("lit_rst_mid_stall", 64'(stall_front), 64'd1);
    apply(0, 1, 5, 0, 1, 1, 6, 0, 0);
    chk("lit_rst_dropped", 64'(stall_front), 64'd0);
    apply(0, 1, 3, 3, 0, 1, 3, 1, 0);
    chk("lit_selfdep", 64'(stall_front), 64'd0);

    // Random traffic over a small register set to provoke collisions
    for (int n = 0; n < 800; n++) begin
      apply(($urandom_range(0, 99) < 2) ? 1 : 0,
            ($urandom_range(0, 99) < 90) ? 1 : 0,
            int'($urandom_range(0, 5)), int'($urandom_range(0, 5)),
            int'($urandom_range(0, 3)), int'($urandom_range(0, 1)),
            int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
            ($urandom_range(0, 99) < 15) ? 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
